// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder.
// The master issues immediates and accepts encoded words.
// The slave (the encoder) does the reverse.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm;
  logic [1:0]  imm_src;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        out_err;

  modport master (
    output in_valid, imm, imm_src, base, out_ready,
    input  in_ready, out_valid, instr, out_err
  );

  modport slave (
    input  in_valid, imm, imm_src, base, out_ready,
    output in_ready, out_valid, instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into the immediate fields
// of a RISC-V instruction word (I/J/U/B formats), flags immediates that the
// format cannot represent, and holds the result in a one-deep output stage
// with valid/ready flow control. Also counts encodes and errors.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] SRC_I = 2'd0;
  localparam logic [1:0] SRC_J = 2'd1;
  localparam logic [1:0] SRC_U = 2'd2;
  localparam logic [1:0] SRC_B = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_reg;
  logic [31:0]      instr_reg;
  logic             out_err_reg;
  logic [CNT_W-1:0] enc_count_reg;
  logic [CNT_W-1:0] err_count_reg;

  logic [31:0]      field_mask;
  logic [31:0]      field_bits;
  logic [31:0]      instr_next;
  logic             err_next;
  logic             accept;

  // A new request may enter whenever the stage is empty or draining now.
  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Field mask, scattered immediate bits and representability per format.
  always_comb begin
    field_mask = 32'h0000_0000;
    field_bits = 32'h0000_0000;
    err_next   = 1'b0;
    unique case (bus.imm_src)
      SRC_I: begin
        field_mask = 32'hFFF0_0000;
        field_bits = {bus.imm[11:0], 20'b0};
        // Must be a sign-extended 12-bit value.
        err_next   = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
      end
      SRC_J: begin
        field_mask = 32'hFFFF_F000;
        field_bits = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], 12'b0};
        // Sign-extended 21-bit value, halfword aligned.
        err_next   = !((&bus.imm[31:20]) || !(|bus.imm[31:20])) || bus.imm[0];
      end
      SRC_U: begin
        field_mask = 32'hFFFF_F000;
        field_bits = {bus.imm[31:12], 12'b0};
        // Low 12 bits have nowhere to go.
        err_next   = |bus.imm[11:0];
      end
      SRC_B: begin
        field_mask = 32'hFE00_0F80;
        field_bits = {bus.imm[12], bus.imm[10:5], 13'b0, bus.imm[4:1], bus.imm[11], 7'b0};
        // Sign-extended 13-bit value, halfword aligned.
        err_next   = !((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0];
      end
      default: begin
        field_mask = 32'h0000_0000;
        field_bits = 32'h0000_0000;
        err_next   = 1'b0;
      end
    endcase
    instr_next = (bus.base & ~field_mask) | field_bits;
  end

  // Output stage: load on accept, empty on drain-only, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      instr_reg     <= 32'h0000_0000;
      out_err_reg   <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      instr_reg     <= instr_next;
      out_err_reg   <= err_next;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Encode counter wraps; error counter saturates; clear wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count_reg <= '0;
      err_count_reg <= '0;
    end else if (clr_cnt) begin
      enc_count_reg <= '0;
      err_count_reg <= '0;
    end else if (accept) begin
      enc_count_reg <= enc_count_reg + CNT_ONE;
      if (err_next && (err_count_reg != CNT_MAX)) begin
        err_count_reg <= err_count_reg + CNT_ONE;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.instr     = instr_reg;
  assign bus.out_err   = out_err_reg;
  assign enc_count     = enc_count_reg;
  assign err_count     = err_count_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: the driver pushes model results on each
// accept, the monitor pops and compares whenever a word leaves the DUT.
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        clr_cnt;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  imm_encoder_if bus();

  imm_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_cnt   (clr_cnt),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_pop_cyc = -10;
  int          prev_pop_cyc = -10;
  bit          verbose = 1'b1;
  logic [15:0] enc_exp = 16'h0;
  logic [15:0] err_exp = 16'h0;
  logic [31:0] held_instr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference: bit-by-bit placement and signed range checks.
  function automatic logic [31:0] model_instr(input logic [31:0] imm, input logic [1:0] src,
                                              input logic [31:0] base);
    logic [31:0] w;
    w = base;
    case (src)
      2'd0: for (int b = 20; b < 32; b++) w[b] = imm[b-20];
      2'd1: begin
        w[31] = imm[20];
        for (int b = 21; b <= 30; b++) w[b] = imm[b-20];
        w[20] = imm[11];
        for (int b = 12; b <= 19; b++) w[b] = imm[b];
      end
      2'd2: for (int b = 12; b < 32; b++) w[b] = imm[b];
      default: begin
        w[31] = imm[12];
        for (int b = 25; b <= 30; b++) w[b] = imm[b-20];
        for (int b = 8; b <= 11; b++) w[b] = imm[b-7];
        w[7] = imm[11];
      end
    endcase
    return w;
  endfunction

  function automatic logic model_err(input logic [31:0] imm, input logic [1:0] src);
    longint s;
    s = longint'($signed(imm));
    case (src)
      2'd0:    return (s < -2048) || (s > 2047);
      2'd1:    return (s < -(64'sd1 <<< 20)) || (s > (64'sd1 <<< 20) - 1) || imm[0];
      2'd2:    return imm[11:0] != 12'h0;
      default: return (s < -4096) || (s > 4095) || imm[0];
    endcase
  endfunction

  task automatic push_expect(input logic [31:0] imm, input logic [1:0] src,
                             input logic [31:0] base, input bit clr);
    exp_t e;
    e.imm   = imm;
    e.src   = src;
    e.instr = model_instr(imm, src, base);
    e.err   = model_err(imm, src);
    sb.push_back(e);
    if (clr) begin
      enc_exp = 16'h0;
      err_exp = 16'h0;
    end else begin
      enc_exp = enc_exp + 16'h1;
      if (e.err && err_exp != 16'hFFFF) err_exp = err_exp + 16'h1;
    end
  endtask

  // Drive one request at a falling edge, hold until accepted, record expectation.
  task automatic send(input logic [31:0] imm, input logic [1:0] src,
                      input logic [31:0] base, input bit clr);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.imm      = imm;
    bus.imm_src  = src;
    bus.base     = base;
    clr_cnt      = clr;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_expect(imm, src, base, clr);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr_cnt      = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_enc"}, 32'(enc_count), 32'(enc_exp));
    check({tag, "_err"}, 32'(err_count), 32'(err_exp));
  endtask

  // Monitor: compare every word that leaves the DUT against the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", bus.instr, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
        if (verbose)
          $display("txn imm=%h src=%0d instr=%h err=%0d (exp %h/%0d)",
                   e.imm, e.src, bus.instr, bus.out_err, e.instr, e.err);
        check("instr", bus.instr, e.instr);
        check("out_err", 32'(bus.out_err), 32'(e.err));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    clr_cnt      = 1'b0;
    bus.in_valid = 1'b0;
    bus.imm      = 32'h0;
    bus.imm_src  = 2'd0;
    bus.base     = 32'h0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_counts("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // I-format, sign-extended all-ones
    send(32'hFFFF_FFFF, 2'd0, 32'h0000_0013, 1'b0);
    idle();
    #1;
    check("i_out_valid", 32'(bus.out_valid), 32'd1);
    check("i_instr_const", bus.instr, 32'hFFF0_0013);
    check_counts("i");
    wait_drain();
    @(negedge clk);
    #1;
    check("drain_only_valid", 32'(bus.out_valid), 32'd0);

    // U then B back to back, no bubble
    send(32'h1234_5000, 2'd2, 32'h0000_0037, 1'b0);
    send(32'hFFFF_FFFC, 2'd3, 32'h0000_0063, 1'b0);
    idle();
    wait_drain();
    check("ub_no_bubble", 32'(last_pop_cyc - prev_pop_cyc), 32'd1);
    check("b_instr_const", model_instr(32'hFFFF_FFFC, 2'd3, 32'h0000_0063), 32'hFE00_0EE3);

    // J good, J misaligned, I overflow
    send(32'h0000_0800, 2'd1, 32'h0000_006F, 1'b0);
    send(32'h0000_0003, 2'd1, 32'h0000_006F, 1'b0);
    send(32'h0000_0800, 2'd0, 32'h0000_0013, 1'b0);
    idle();
    #1;
    check("i_ovf_instr", bus.instr, 32'h8000_0013);
    check("i_ovf_err", 32'(bus.out_err), 32'd1);
    wait_drain();
    check_counts("jerr");
    check("jerr_errcnt_const", 32'(err_count), 32'd2);

    // Random vectors, small immediates biased to hit both legal and illegal cases
    for (int k = 0; k < 24; k++) begin
      logic [31:0] ri;
      ri = (k % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 16383)) - 8192);
      send(ri, 2'($urandom_range(0, 3)), $urandom, 1'b0);
    end
    idle();
    wait_drain();
    check_counts("rand");

    // Backpressure: hold A for 5 cycles with B pending, then drain+accept together
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(32'h0000_07FF, 2'd0, 32'h0000_0093, 1'b0);
    held_instr = model_instr(32'h0000_07FF, 2'd0, 32'h0000_0093);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.imm      = 32'hFFFF_F000;
    bus.imm_src  = 2'd2;
    bus.base     = 32'h0000_0537;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_instr_hold", bus.instr, held_instr);
      check("bp_enc_hold", 32'(enc_count), 32'(enc_exp));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    push_expect(32'hFFFF_F000, 2'd2, 32'h0000_0537, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("bp_valid_kept", 32'(bus.out_valid), 32'd1);
    check("bp_new_instr", bus.instr, 32'hFFFF_F537);
    wait_drain();
    check_counts("bp");

    // Saturate err_count with repeated errors
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    enc_exp = 16'h0;
    err_exp = 16'h0;
    verbose = 1'b0;
    for (int k = 0; k < 65535; k++) send(32'h0000_0003, 2'd1, 32'h0000_006F, 1'b0);
    idle();
    wait_drain();
    check("sat_reach", 32'(err_count), 32'h0000_FFFF);
    check_counts("sat_reach");
    verbose = 1'b1;
    send(32'h0000_0003, 2'd1, 32'h0000_006F, 1'b0);
    idle();
    wait_drain();
    check("sat_hold", 32'(err_count), 32'h0000_FFFF);
    check_counts("sat_hold");

    // Clear together with an accept
    send(32'h0000_0005, 2'd0, 32'h0000_0013, 1'b1);
    idle();
    #1;
    check("clr_enc", 32'(enc_count), 32'd0);
    check("clr_err", 32'(err_count), 32'd0);
    wait_drain();

    // Reset while a word is held
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(32'h0000_0010, 2'd0, 32'h0000_0013, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_instr", bus.instr, 32'h0);
    check("async_rst_enc", 32'(enc_count), 32'd0);
    sb.delete();
    enc_exp = 16'h0;
    err_exp = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(32'h0000_0123, 2'd0, 32'h0000_0013, 1'b0);
    idle();
    wait_drain();
    check_counts("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
